// File: rtl/verinject_mem1_fault_tracker.sv
// Latent single-bit fault tracker for one instrumented memory: holds an injected upset in a
// target word, corrupts reads of that word, and reports when a write overwrites the cell.
module verinject_mem1_fault_tracker #(
    parameter int          LEFT       = 0,
    parameter int          RIGHT      = 0,
    parameter int          ADDR_LEFT  = 0,
    parameter int          ADDR_RIGHT = 0,
    parameter int          MEM_LEFT   = 0,
    parameter int          MEM_RIGHT  = 0,
    parameter int unsigned P_START    = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [31:0]                   verinject__injector_state,
    input  logic                          inject_strobe,
    input  logic [ADDR_LEFT:ADDR_RIGHT]   read_address,
    input  logic [LEFT:RIGHT]             unmodified,
    output logic [LEFT:RIGHT]             modified,
    input  logic                          do_write,
    input  logic [ADDR_LEFT:ADDR_RIGHT]   write_address,
    output logic                          fault_active,
    output logic                          fault_observed,
    output logic                          fault_overwritten,
    output logic [CNT_WIDTH-1:0]          observed_count
);

    localparam int unsigned WordLen   = (LEFT > RIGHT) ? LEFT - RIGHT + 1 : RIGHT - LEFT + 1;
    localparam int unsigned MemLen    = (MEM_LEFT > MEM_RIGHT) ? MEM_LEFT - MEM_RIGHT + 1
                                                               : MEM_RIGHT - MEM_LEFT + 1;
    localparam int unsigned AddrLen   = (ADDR_LEFT > ADDR_RIGHT) ? ADDR_LEFT - ADDR_RIGHT + 1
                                                                 : ADDR_RIGHT - ADDR_LEFT + 1;
    localparam int unsigned TotalBits = MemLen * WordLen;

    localparam logic [WordLen-1:0]   WordOne = WordLen'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StLatent, StObserved, StOverwritten} state_e;

    state_e               state_q, state_d;
    logic [31:0]          word_idx_q, word_idx_d;
    logic [31:0]          bit_idx_q, bit_idx_d;
    logic                 observed_q, observed_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic [31:0]        offset;
    logic               in_range;
    logic               armed;
    logic               rd_hit;
    logic               wr_hit;
    logic [AddrLen-1:0] rd_addr;
    logic [AddrLen-1:0] wr_addr;
    logic [WordLen-1:0] raw_word;
    logic [WordLen-1:0] mod_word;

    // Vector ranges are normalised to [N-1:0] so address and bit weights are purely numeric.
    assign rd_addr  = read_address;
    assign wr_addr  = write_address;
    assign raw_word = unmodified;

    // Offset form avoids overflow of P_START + TotalBits.
    assign offset   = verinject__injector_state - P_START;
    assign in_range = (verinject__injector_state >= P_START) && (offset < TotalBits);

    assign armed  = (state_q == StLatent) || (state_q == StObserved);
    assign rd_hit = armed && (32'(rd_addr) == word_idx_q);
    assign wr_hit = armed && do_write && (32'(wr_addr) == word_idx_q);

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        bit_idx_d  = bit_idx_q;
        observed_d = observed_q;
        count_d    = count_q;
        if (inject_strobe) begin
            observed_d = 1'b0;
            count_d    = '0;
            if (in_range) begin
                state_d    = StLatent;
                word_idx_d = offset / WordLen;
                bit_idx_d  = offset % WordLen;
            end else begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StLatent, StObserved: begin
                    // A same-cycle read is seen before the write lands, so it still counts.
                    if (rd_hit) begin
                        state_d    = StObserved;
                        observed_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + CntOne;
                        end
                    end
                    if (wr_hit) begin
                        state_d = StOverwritten;
                    end
                end
                StOverwritten: state_d = StIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            word_idx_q <= '0;
            bit_idx_q  <= '0;
            observed_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            bit_idx_q  <= bit_idx_d;
            observed_q <= observed_d;
            count_q    <= count_d;
        end
    end

    assign mod_word          = raw_word ^ (rd_hit ? (WordOne << bit_idx_q) : '0);
    assign modified          = mod_word;
    assign fault_active      = armed;
    assign fault_observed    = observed_q;
    assign fault_overwritten = (state_q == StOverwritten);
    assign observed_count    = count_q;

endmodule

// File: doc/verinject_mem1_fault_tracker.md
Name: verinject_mem1_fault_tracker

Overview:
- Stateful companion to the combinational memory read injector. It models a transient single-bit upset as a latent corruption stored in one memory word.
- On an inject strobe it latches a target bit. It corrupts every read of that word until a write to the same address overwrites the cell.
- It then reports the fault as overwritten.
- It sits beside each instrumented memory and provides fault lifetime tracking for campaign statistics.

Parameters:
- LEFT, 0, left index of the memory word
- RIGHT, 0, right index of the memory word; word_len = |LEFT-RIGHT|+1
- ADDR_LEFT, 0, left index of the address ports
- ADDR_RIGHT, 0, right index of the address ports
- MEM_LEFT, 0, first declared index of the memory array
- MEM_RIGHT, 0, last declared index of the memory array; mem_len = |MEM_LEFT-MEM_RIGHT|+1
- P_START, 0, global bit index of this memory's first bit
- CNT_WIDTH, 16, width of the observed-read counter

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- verinject__injector_state  input  32  global target bit index; sampled only when inject_strobe=1
- inject_strobe  input  1  one-cycle request to latch a new fault
- read_address  input  [ADDR_LEFT:ADDR_RIGHT]  current read address
- unmodified  input  [LEFT:RIGHT]  raw read data
- modified  output  [LEFT:RIGHT]  read data with the fault applied; combinational
- do_write  input  1  write enable of the memory
- write_address  input  [ADDR_LEFT:ADDR_RIGHT]  write address
- fault_active  output  1  a latent fault is present (state LATENT or OBSERVED)
- fault_observed  output  1  sticky; at least one read has seen the current fault
- fault_overwritten  output  1  one-cycle pulse when a write clears the fault
- observed_count  output  CNT_WIDTH  number of faulty reads for the current fault, saturating

Behaviour:
- Range check:
  - Target is in range iff P_START <= state < P_START + mem_len*word_len, computed in 32-bit unsigned arithmetic.
  - word_idx = (state-P_START)/word_len and bit_idx = (state-P_START)%word_len, both latched into registers.
- Address and bit mapping:
  - Addresses are compared numerically against word_idx. Address 0 is the first word.
  - bit_idx k flips the bit of numeric weight 2^k, i.e. counted from the RIGHT end of the vector.
- States: IDLE, LATENT, OBSERVED, OVERWRITTEN.
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; word_idx and bit_idx are cleared.
  - fault_active=0, fault_observed=0, fault_overwritten=0, observed_count=0.
  - Reset mid-fault discards the fault, with no overwritten pulse.
- inject_strobe=1 with target in range:
  - Next state is LATENT from any state.
  - word_idx and bit_idx are reloaded; observed_count and fault_observed are cleared.
  - The strobe has priority over a write in the same cycle, so the write is treated as landing before the upset.
- inject_strobe=1 with target out of range: next state is IDLE, and the counters are cleared.
- Read path (combinational):
  - In LATENT or OBSERVED with read_address==word_idx: modified = unmodified XOR (1<<bit_idx).
  - Otherwise modified = unmodified.
  - Every cycle is treated as a read cycle; there is no read enable.
- Read accounting:
  - In LATENT or OBSERVED, a cycle with read_address==word_idx and no strobe moves LATENT to OBSERVED and sets fault_observed.
  - The same cycle increments observed_count, saturating at all-ones.
- Write clear:
  - In LATENT or OBSERVED, do_write=1 with write_address==word_idx and no strobe moves the state to OVERWRITTEN.
  - fault_overwritten pulses high for exactly the following cycle.
- Simultaneous read and write to the target word in the same cycle:
  - The read is still corrupted (read-before-write) and is counted.
  - The state then goes to OVERWRITTEN.
- OVERWRITTEN:
  - modified is passthrough and fault_active=0.
  - fault_observed and observed_count hold their values for software readout.
  - Moves to IDLE the next cycle unless a strobe is present. fault_observed and observed_count persist until the next strobe or reset.
- IDLE: modified is passthrough; writes and reads have no effect.
- Latency:
  - Fault visibility on modified starts the cycle after the strobe edge.
  - fault_active is registered.

Test Plan:
Common configuration: LEFT=7, RIGHT=0, ADDR 3:0, MEM 0:15, P_START=100 (valid range 100..227).
- Reset with clock stopped -> all outputs 0 immediately; modified==unmodified for any read.
- Strobe with state=119 (word 2, bit 3), then read addr 2 with unmodified=0x00 -> modified=0x08, fault_observed=1, observed_count=1; a read of addr 3 passes through unchanged.
- After the fault is latched, do_write at addr 2 -> fault_overwritten high for exactly one cycle, fault_active=0; a later read of addr 2 with 0x55 returns 0x55; observed_count holds its value.
- Strobe with state=228, and separately with state=99 -> state stays IDLE, fault_active=0, no corruption at any address.
- Strobe state=227 (word 15, bit 7), then read addr 15 and write addr 15 in the same cycle with unmodified=0x01 -> modified=0x81, count=1, then OVERWRITTEN.
- Strobe in the same cycle as a write to the target word -> LATENT; the next read is corrupted. A second strobe to word 5 retargets the fault and zeroes the count. Asserting reset while OBSERVED clears everything with no pulse.
